// File: rtl/bp_resolve_queue.sv
// In-flight branch-prediction tracker: FIFO of fetch-time predictions, popped as
// instructions leave EX and compared against the resolved outcome to drive BTB updates.
module bp_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic             fetch_pred_taken,
    input  logic [31:0]      fetch_pred_target,
    input  logic [1:0]       fetch_pred_rdata,
    output logic             enq_ready,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic             ex_br_en,
    input  logic [31:0]      ex_target,
    input  logic             flush,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_mispredict,
    output logic             upd_wrong_pc,
    output logic [31:0]      upd_target,
    output logic [1:0]       upd_rdata,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic             err_underflow
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Prediction storage; the head is read combinationally so it can be
    // compared against the resolved outcome in the same cycle it is popped.
    logic [31:0] pc_mem     [DEPTH];
    logic        taken_mem  [DEPTH];
    logic [31:0] target_mem [DEPTH];
    logic [1:0]  rdata_mem  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_pc_q, upd_pc_d;
    logic             upd_mispredict_q, upd_mispredict_d;
    logic             upd_wrong_pc_q, upd_wrong_pc_d;
    logic [31:0]      upd_target_q, upd_target_d;
    logic [1:0]       upd_rdata_q, upd_rdata_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;
    logic             err_underflow_q, err_underflow_d;

    logic        not_full;
    logic        not_empty;
    logic        do_enq;
    logic        do_deq;
    logic        head_taken;
    logic [31:0] head_target;
    logic        mis_dir;
    logic        mis_tgt;

    always_comb begin
        not_full    = (count_q != FULL_OCC);
        not_empty   = (count_q != '0);
        do_enq      = fetch_valid & not_full & ~flush;
        do_deq      = ex_valid & not_empty;
        head_taken  = taken_mem[head_q];
        head_target = target_mem[head_q];
        mis_dir     = head_taken ^ ex_br_en;
        mis_tgt     = ex_br_en & (~head_taken | (head_target != ex_target));
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // A redirect wins over any same-cycle enqueue; the pop itself is still
        // evaluated below because the redirect originates from that branch.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(do_deq);
            tail_d  = tail_q + PTR_W'(do_enq);
            count_d = count_q + OCC_W'(do_enq) - OCC_W'(do_deq);
        end
    end

    always_comb begin
        upd_valid_d      = do_deq & ex_is_br;
        upd_mispredict_d = 1'b0;
        upd_wrong_pc_d   = 1'b0;
        upd_pc_d         = upd_pc_q;
        upd_target_d     = upd_target_q;
        upd_rdata_d      = upd_rdata_q;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;
        err_underflow_d  = err_underflow_q | (ex_valid & ~not_empty);
        if (upd_valid_d) begin
            upd_mispredict_d = mis_dir;
            upd_wrong_pc_d   = mis_tgt;
            upd_pc_d         = pc_mem[head_q];
            upd_target_d     = ex_target;
            upd_rdata_d      = rdata_mem[head_q];
            if (br_count_q != CNT_MAX) begin
                br_count_d = br_count_q + CNT_W'(1);
            end
            if ((mis_dir | mis_tgt) && (mispred_count_q != CNT_MAX)) begin
                mispred_count_d = mispred_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_mem[tail_q]     <= fetch_pc;
            taken_mem[tail_q]  <= fetch_pred_taken;
            target_mem[tail_q] <= fetch_pred_target;
            rdata_mem[tail_q]  <= fetch_pred_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_mispredict_q <= 1'b0;
            upd_wrong_pc_q   <= 1'b0;
            upd_target_q     <= '0;
            upd_rdata_q      <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
            err_underflow_q  <= 1'b0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_mispredict_q <= upd_mispredict_d;
            upd_wrong_pc_q   <= upd_wrong_pc_d;
            upd_target_q     <= upd_target_d;
            upd_rdata_q      <= upd_rdata_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
            err_underflow_q  <= err_underflow_d;
        end
    end

    assign enq_ready      = not_full;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_mispredict = upd_mispredict_q;
    assign upd_wrong_pc   = upd_wrong_pc_q;
    assign upd_target     = upd_target_q;
    assign upd_rdata      = upd_rdata_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;
    assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Bench for bp_resolve_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the prediction tracker.
module tb_bp_resolve_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fetch_valid = 1'b0;
    logic [31:0]      fetch_pc = '0;
    logic             fetch_pred_taken = 1'b0;
    logic [31:0]      fetch_pred_target = '0;
    logic [1:0]       fetch_pred_rdata = '0;
    logic             enq_ready;
    logic             ex_valid = 1'b0;
    logic             ex_is_br = 1'b0;
    logic             ex_br_en = 1'b0;
    logic [31:0]      ex_target = '0;
    logic             flush = 1'b0;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_mispredict;
    logic             upd_wrong_pc;
    logic [31:0]      upd_target;
    logic [1:0]       upd_rdata;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;
    logic             err_underflow;

    always #5 clk = ~clk;

    bp_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
        .fetch_pred_rdata(fetch_pred_rdata), .enq_ready(enq_ready),
        .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_br_en(ex_br_en),
        .ex_target(ex_target), .flush(flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_mispredict(upd_mispredict),
        .upd_wrong_pc(upd_wrong_pc), .upd_target(upd_target), .upd_rdata(upd_rdata),
        .br_count(br_count), .mispred_count(mispred_count), .err_underflow(err_underflow)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  rdata;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    logic        m_v, m_mis, m_wpc, m_err;
    logic [31:0] m_pc, m_tgt;
    logic [1:0]  m_rd;
    int          m_br, m_mc;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        mq.delete();
        m_v = 0; m_mis = 0; m_wpc = 0; m_err = 0;
        m_pc = '0; m_tgt = '0; m_rd = '0;
        m_br = 0; m_mc = 0;
    endtask

    task automatic idle_inputs();
        fetch_valid = 0; fetch_pc = '0; fetch_pred_taken = 0;
        fetch_pred_target = '0; fetch_pred_rdata = '0;
        ex_valid = 0; ex_is_br = 0; ex_br_en = 0; ex_target = '0; flush = 0;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic tk,
                             input logic [31:0] tg, input logic [1:0] rd);
        fetch_valid = 1; fetch_pc = pc; fetch_pred_taken = tk;
        fetch_pred_target = tg; fetch_pred_rdata = rd;
    endtask

    task automatic set_ex(input logic br, input logic en, input logic [31:0] tg);
        ex_valid = 1; ex_is_br = br; ex_br_en = en; ex_target = tg;
    endtask

    // Advance one clock; the model consumes the inputs presented at that edge.
    task automatic tick();
        ent_t e;
        bit   can_enq;
        @(posedge clk);
        can_enq = (mq.size() != DEPTH);
        m_v = 0; m_mis = 0; m_wpc = 0;
        if (ex_valid && mq.size() == 0) m_err = 1;
        if (ex_valid && mq.size() != 0) begin
            e = mq.pop_front();
            if (ex_is_br) begin
                m_v   = 1;
                m_pc  = e.pc;
                m_mis = e.taken ^ ex_br_en;
                m_wpc = ex_br_en && (!e.taken || e.target != ex_target);
                m_tgt = ex_target;
                m_rd  = e.rdata;
                if (m_br < CMAX) m_br++;
                if ((m_mis || m_wpc) && m_mc < CMAX) m_mc++;
            end
        end
        if (flush) mq.delete();
        else if (fetch_valid && can_enq)
            mq.push_back('{pc: fetch_pc, taken: fetch_pred_taken,
                           target: fetch_pred_target, rdata: fetch_pred_rdata});
        #1;
        idle_inputs();
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        sync_reset();
        #1;
        checks++;
        if (enq_ready !== 1'b1 || upd_valid !== 1'b0 || br_count !== '0 ||
            mispred_count !== '0 || err_underflow !== 1'b0 || upd_pc !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b br=%0d mc=%0d err=%b pc=%h required 1 0 0 0 0 0",
                     enq_ready, upd_valid, br_count, mispred_count, err_underflow, upd_pc);
        end
    endtask

    task automatic test_reset_mid();
        ex_valid = 1; tick();                // underflow makes err sticky
        for (int i = 0; i < 3; i++) begin
            set_fetch(32'h500 + 4 * i, 0, 0, 2'd1); tick();
        end
        set_ex(1, 1, 32'h77); set_fetch(32'h50C, 0, 0, 0); tick();
        checks++;
        if (upd_valid !== 1'b1 || err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got v=%b err=%b required 1 1", upd_valid, err_underflow);
        end
        #2 rst = 0;
        #1;
        checks++;
        if (enq_ready !== 1'b1 || upd_valid !== 1'b0 || br_count !== '0 ||
            mispred_count !== '0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b v=%b br=%0d mc=%0d err=%b required 1 0 0 0 0",
                     enq_ready, upd_valid, br_count, mispred_count, err_underflow);
        end
        model_reset();
        @(negedge clk); rst = 1;
        // Queue must be empty: exactly DEPTH fetches fit again.
        for (int i = 0; i < DEPTH; i++) begin
            set_fetch(32'h600 + 4 * i, 0, 0, 0); tick();
            checks++;
            if (enq_ready !== (i != DEPTH - 1)) begin
                errors++;
                $display("FAIL reset_empty_%0d: got rdy=%b required %b", i, enq_ready, i != DEPTH - 1);
            end
        end
        sync_reset();
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < DEPTH; i++) begin
            set_fetch(32'h100 + 4 * i, 0, 32'h0, 2'd0); tick();
        end
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b required 0", enq_ready);
        end
        set_fetch(32'h110, 0, 0, 0); tick();  // dropped while full
        for (int i = 0; i < DEPTH; i++) begin
            set_ex(1, 0, 32'h0); tick();
            checks++;
            if (upd_valid !== 1'b1 || upd_pc !== 32'h100 + 4 * i) begin
                errors++;
                $display("FAIL fifo_order_%0d: got v=%b pc=%h required 1 %h",
                         i, upd_valid, upd_pc, 32'h100 + 4 * i);
            end
        end
        ex_valid = 1; ex_is_br = 1; tick();
        checks++;
        if (upd_valid !== 1'b0 || err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_when_full: got v=%b err=%b required 0 1", upd_valid, err_underflow);
        end
        sync_reset();
    endtask

    task automatic test_compare();
        set_fetch(32'h200, 1, 32'h240, 2'b11); tick();
        set_ex(1, 1, 32'h240); tick();
        checks++;
        if (upd_valid !== 1 || upd_mispredict !== 0 || upd_wrong_pc !== 0 ||
            upd_rdata !== 2'b11 || upd_pc !== 32'h200) begin
            errors++;
            $display("FAIL correct_pred: got v=%b mis=%b wpc=%b rd=%b pc=%h required 1 0 0 11 200",
                     upd_valid, upd_mispredict, upd_wrong_pc, upd_rdata, upd_pc);
        end
        tick();
        checks++;
        if (upd_valid !== 0 || upd_pc !== 32'h200 || upd_rdata !== 2'b11 || mispred_count !== 0) begin
            errors++;
            $display("FAIL pulse_hold: got v=%b pc=%h rd=%b mc=%0d required 0 200 11 0",
                     upd_valid, upd_pc, upd_rdata, mispred_count);
        end
        set_fetch(32'h200, 1, 32'h240, 2'b11); tick();
        set_ex(1, 1, 32'h280); tick();
        checks++;
        if (upd_wrong_pc !== 1 || upd_mispredict !== 0 || upd_target !== 32'h280) begin
            errors++;
            $display("FAIL wrong_target: got wpc=%b mis=%b tgt=%h required 1 0 280",
                     upd_wrong_pc, upd_mispredict, upd_target);
        end
        tick();
        checks++;
        if (mispred_count !== 4'd1 || br_count !== 4'd2 || upd_wrong_pc !== 0) begin
            errors++;
            $display("FAIL mispred_cnt: got mc=%0d br=%0d wpc=%b required 1 2 0",
                     mispred_count, br_count, upd_wrong_pc);
        end
        set_fetch(32'h200, 1, 32'h240, 2'b11); tick();
        set_ex(1, 0, 32'h240); tick();
        checks++;
        if (upd_mispredict !== 1 || upd_wrong_pc !== 0) begin
            errors++;
            $display("FAIL wrong_dir: got mis=%b wpc=%b required 1 0", upd_mispredict, upd_wrong_pc);
        end
        set_fetch(32'h210, 0, 32'h0, 2'b01); tick();
        set_ex(0, 1, 32'h999); tick();
        checks++;
        if (upd_valid !== 0 || upd_target !== 32'h240 || upd_rdata !== 2'b11) begin
            errors++;
            $display("FAIL non_branch: got v=%b tgt=%h rd=%b required 0 240 11",
                     upd_valid, upd_target, upd_rdata);
        end
        tick();
        checks++;
        if (br_count !== 4'd3 || mispred_count !== 4'd2) begin
            errors++;
            $display("FAIL counts: got br=%0d mc=%0d required 3 2", br_count, mispred_count);
        end
        sync_reset();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_fetch(32'h300 + 4 * i, 1, 32'h340, 2'd2); tick();
        end
        set_ex(1, 1, 32'h3F0); flush = 1; set_fetch(32'h30C, 0, 0, 0); tick();
        checks++;
        if (upd_valid !== 1 || upd_pc !== 32'h300 || upd_wrong_pc !== 1) begin
            errors++;
            $display("FAIL flush_update: got v=%b pc=%h wpc=%b required 1 300 1",
                     upd_valid, upd_pc, upd_wrong_pc);
        end
        ex_valid = 1; ex_is_br = 1; tick();
        checks++;
        if (upd_valid !== 0 || err_underflow !== 1) begin
            errors++;
            $display("FAIL flush_empty: got v=%b err=%b required 0 1", upd_valid, err_underflow);
        end
        set_fetch(32'h700, 0, 0, 0); tick();
        set_ex(1, 0, 0); tick();
        checks++;
        if (upd_pc !== 32'h700 || err_underflow !== 1) begin
            errors++;
            $display("FAIL post_flush_head: got pc=%h err=%b required 700 1", upd_pc, err_underflow);
        end
    endtask

    task automatic test_saturate();
        sync_reset();
        set_fetch(32'h800, 0, 0, 0); tick();
        for (int i = 0; i < 18; i++) begin
            set_fetch(32'h804 + 4 * i, 0, 0, 0); set_ex(1, 1, 32'h1); tick();
        end
        tick(); tick();
        checks++;
        if (br_count !== 4'hF || mispred_count !== 4'hF) begin
            errors++;
            $display("FAIL saturate: got br=%h mc=%h required F F", br_count, mispred_count);
        end
        sync_reset();
    endtask

    task automatic test_random();
        logic [31:0] tg[4];
        tg[0] = 32'h400; tg[1] = 32'h440; tg[2] = 32'h480; tg[3] = 32'h4C0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 55)
                set_fetch($urandom, 1'($urandom_range(0, 1)), tg[$urandom_range(0, 3)],
                          2'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) < 45)
                set_ex($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), tg[$urandom_range(0, 3)]);
            flush = ($urandom_range(0, 99) < 4);
            if (n == 200) begin
                sync_reset();
            end else begin
                tick();
            end
            checks++;
            if (enq_ready !== (mq.size() != DEPTH) || upd_valid !== m_v ||
                upd_mispredict !== m_mis || upd_wrong_pc !== m_wpc || upd_pc !== m_pc ||
                upd_target !== m_tgt || upd_rdata !== m_rd || err_underflow !== m_err) begin
                errors++;
                $display("FAIL rand_%0d: got rdy=%b v=%b mis=%b wpc=%b pc=%h tgt=%h rd=%b err=%b required %b %b %b %b %h %h %b %b",
                         n, enq_ready, upd_valid, upd_mispredict, upd_wrong_pc, upd_pc, upd_target,
                         upd_rdata, err_underflow, mq.size() != DEPTH, m_v, m_mis, m_wpc, m_pc,
                         m_tgt, m_rd, m_err);
            end
            if (!m_v) begin
                checks++;
                if (br_count !== CNT_W'(m_br) || mispred_count !== CNT_W'(m_mc)) begin
                    errors++;
                    $display("FAIL rand_cnt_%0d: got br=%0d mc=%0d required %0d %0d",
                             n, br_count, mispred_count, m_br, m_mc);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        idle_inputs();
        test_reset();
        test_reset_mid();
        test_fill_order();
        test_compare();
        test_flush();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
